// File: rtl/draw_arbiter_if.sv
// Bundle between the draw engines and the framebuffer write-port arbiter.
// Engines drive the request/pixel side (master); the arbiter drives the grant/VGA side (slave).
interface draw_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned XW      = 9,
  parameter int unsigned YW      = 8,
  parameter int unsigned CW      = 3
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    done;
  logic [NUM_REQ-1:0]    plot_in;
  logic [NUM_REQ*XW-1:0] x_in;
  logic [NUM_REQ*YW-1:0] y_in;
  logic [NUM_REQ*CW-1:0] colour_in;
  logic [NUM_REQ-1:0]    grant;
  logic [XW-1:0]         vga_x;
  logic [YW-1:0]         vga_y;
  logic [CW-1:0]         vga_colour;
  logic                  vga_plot;
  logic                  busy;
  logic                  timeout;

  modport master (
    output req, done, plot_in, x_in, y_in, colour_in,
    input  grant, vga_x, vga_y, vga_colour, vga_plot, busy, timeout
  );

  modport slave (
    input  req, done, plot_in, x_in, y_in, colour_in,
    output grant, vga_x, vga_y, vga_colour, vga_plot, busy, timeout
  );
endinterface

// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing the VGA framebuffer write port among NUM_REQ draw engines.
// The owner keeps the port until it pulses done or drops req; one release cycle separates owners.
// Optional watchdog: define DRAW_ARB_WATCHDOG_EN to revoke a grant held MAX_HOLD cycles.
module draw_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned XW       = 9,
  parameter int unsigned YW       = 8,
  parameter int unsigned CW       = 3,
  parameter int unsigned MAX_HOLD = 4096
) (
  input logic           clock,
  input logic           resetn,
  draw_arbiter_if.slave bus
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] owner;
  logic [IW-1:0] sel_c;
  logic [IW-1:0] idx_c;
  logic          found_c;
  logic          exit_c;
  logic          wd_hit_c;

  logic [XW-1:0] x_arr [NUM_REQ];
  logic [YW-1:0] y_arr [NUM_REQ];
  logic [CW-1:0] c_arr [NUM_REQ];

  // Unpack the per-engine pixel buses so the owner can be selected by index.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign x_arr[i] = bus.x_in[i*XW +: XW];
    assign y_arr[i] = bus.y_in[i*YW +: YW];
    assign c_arr[i] = bus.colour_in[i*CW +: CW];
  end

  // Round-robin pick: first requester after the previous owner.
  always_comb begin
    sel_c   = last;
    idx_c   = last;
    found_c = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx_c = IW'((32'(last) + k) % NUM_REQ);
      if (!found_c && bus.req[idx_c]) begin
        sel_c   = idx_c;
        found_c = 1'b1;
      end
    end
  end

`ifdef DRAW_ARB_WATCHDOG_EN
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HW-1:0] hold_cnt;

  assign wd_hit_c = (state == S_GRANT) && (hold_cnt == HW'(MAX_HOLD - 1));

  // Hold counter: zero while no grant is held, counts every owned cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hold_cnt <= '0;
    end else if (state == S_GRANT) begin
      hold_cnt <= hold_cnt + HW'(1);
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  logic [31:0] unused_max_hold;
  assign unused_max_hold = MAX_HOLD;
  assign wd_hit_c = 1'b0;
`endif

  // Owner leaves on its own done, on dropping its request, or on watchdog revoke.
  assign exit_c = bus.done[owner] | ~bus.req[owner] | wd_hit_c;

  // Arbitration FSM with registered grant and VGA outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      last           <= IW'(NUM_REQ - 1);
      owner          <= '0;
      bus.grant      <= '0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.timeout    <= 1'b0;
    end else begin
      bus.vga_plot <= 1'b0;
      bus.timeout  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            owner     <= sel_c;
            bus.grant <= NUM_REQ'(1'b1) << sel_c;
            bus.busy  <= 1'b1;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          // The pixel in the exit cycle is still written.
          bus.vga_x      <= x_arr[owner];
          bus.vga_y      <= y_arr[owner];
          bus.vga_colour <= c_arr[owner];
          bus.vga_plot   <= bus.plot_in[owner];
          if (exit_c) begin
            bus.grant   <= '0;
            bus.busy    <= 1'b0;
            bus.timeout <= wd_hit_c;
            last        <= owner;
            state       <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: begin
          bus.grant <= '0;
          bus.busy  <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_draw_arbiter;
  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned XW       = 9;
  localparam int unsigned YW       = 8;
  localparam int unsigned CW       = 3;
  localparam int unsigned MAX_HOLD = 16;
`ifdef DRAW_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  draw_arbiter_if #(.NUM_REQ(NUM_REQ), .XW(XW), .YW(YW), .CW(CW)) bus ();

  draw_arbiter #(
    .NUM_REQ(NUM_REQ), .XW(XW), .YW(YW), .CW(CW), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  // Behavioural model: who owns the port, how long, and the forced gap after a release.
  int                 m_owner = -1;
  int                 m_last = NUM_REQ - 1;
  int                 m_gap = 0;
  int                 m_hold = 0;
  logic [NUM_REQ-1:0] exp_grant = '0;
  logic               exp_busy = 1'b0;
  logic               exp_plot = 1'b0;
  logic               exp_to = 1'b0;
  logic [XW-1:0]      exp_x = '0;
  logic [YW-1:0]      exp_y = '0;
  logic [CW-1:0]      exp_c = '0;

  // Model update on each edge from the same inputs the DUT samples.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_owner = -1; m_last = NUM_REQ - 1; m_gap = 0; m_hold = 0;
      exp_grant = '0; exp_busy = 1'b0; exp_plot = 1'b0; exp_to = 1'b0;
      exp_x = '0; exp_y = '0; exp_c = '0;
    end else begin
      exp_plot = 1'b0;
      exp_to = 1'b0;
      if (m_owner >= 0) begin
        exp_plot = bus.plot_in[m_owner];
        exp_x = XW'(bus.x_in >> (m_owner * XW));
        exp_y = YW'(bus.y_in >> (m_owner * YW));
        exp_c = CW'(bus.colour_in >> (m_owner * CW));
        m_hold++;
        if (bus.done[m_owner] || !bus.req[m_owner] || (WD && m_hold == MAX_HOLD)) begin
          exp_to = WD && (m_hold == MAX_HOLD);
          m_last = m_owner;
          m_owner = -1;
          m_gap = 1;
          exp_grant = '0;
          exp_busy = 1'b0;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (bus.req != '0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int i;
          i = (m_last + k) % NUM_REQ;
          if (m_owner < 0 && bus.req[i]) m_owner = i;
        end
        m_hold = 0;
        exp_grant = NUM_REQ'(1) << m_owner;
        exp_busy = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  task automatic compare_loop();
    forever begin
      @(negedge clock);
      check("grant", 32'(bus.grant), 32'(exp_grant));
      check("busy", 32'(bus.busy), 32'(exp_busy));
      check("vga_plot", 32'(bus.vga_plot), 32'(exp_plot));
      check("timeout", 32'(bus.timeout), 32'(exp_to));
      if (exp_plot) begin
        check("vga_x", 32'(bus.vga_x), 32'(exp_x));
        check("vga_y", 32'(bus.vga_y), 32'(exp_y));
        check("vga_colour", 32'(bus.vga_colour), 32'(exp_c));
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pix(input int e, input int p, input int x, input int y, input int c);
    bus.plot_in[e] = p[0];
    bus.x_in[e*XW +: XW] = XW'(x);
    bus.y_in[e*YW +: YW] = YW'(y);
    bus.colour_in[e*CW +: CW] = CW'(c);
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.done = '0; bus.plot_in = '0;
    bus.x_in = '0; bus.y_in = '0; bus.colour_in = '0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  // Wait (bounded) for any grant; returns the granted index or -1.
  task automatic wait_grant(output int idx);
    int n;
    n = 0;
    idx = -1;
    while (bus.grant == '0 && n < 20) begin
      tick();
      n++;
    end
    if (bus.grant == '0) begin
      check("wait_grant_timeout", 32'(bus.grant), 32'(1));
    end else begin
      for (int i = 0; i < NUM_REQ; i++) if (bus.grant[i]) idx = i;
    end
  endtask

  initial begin
    int idx;
    int n;
    int exp_order[5];
    logic to_seen;
    exp_order = '{0, 1, 2, 3, 0};

    apply_reset();
    fork
      compare_loop();
    join_none

    // Reset values
    check("rst_grant", 32'(bus.grant), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_plot", 32'(bus.vga_plot), 32'(0));
    check("rst_vga_x", 32'(bus.vga_x), 32'(0));
    check("rst_timeout", 32'(bus.timeout), 32'(0));

    // Single requester: grant after one edge, pixel one edge later
    bus.req = 4'b0001;
    set_pix(0, 1, 100, 50, 5);
    tick();
    check("first_grant", 32'(bus.grant), 32'(1));
    tick();
    check("first_x", 32'(bus.vga_x), 32'(100));
    check("first_y", 32'(bus.vga_y), 32'(50));
    check("first_plot", 32'(bus.vga_plot), 32'(1));

    // All request, owners finish after 3 cycles: order 0,1,2,3,0
    apply_reset();
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_grant(idx);
      check("rr_order", 32'(idx), 32'(exp_order[t]));
      tick();
      tick();
      if (idx >= 0) bus.done[idx] = 1'b1;
      tick();
      bus.done = '0;
    end

    // Non-owner pixels are ignored
    apply_reset();
    bus.req = 4'b0100;
    wait_grant(idx);
    check("owner2", 32'(idx), 32'(2));
    bus.req[1] = 1'b1;
    set_pix(1, 1, 7, 9, 1);
    set_pix(2, 0, 33, 20, 2);
    tick();
    check("nonowner_plot", 32'(bus.vga_plot), 32'(0));
    set_pix(2, 1, 33, 20, 2);
    tick();
    check("owner_x", 32'(bus.vga_x), 32'(33));
    check("owner_plot", 32'(bus.vga_plot), 32'(1));

    // Asynchronous reset while engine 2 owns and plots
    #2;
    resetn = 1'b0;
    #1;
    check("async_grant", 32'(bus.grant), 32'(0));
    check("async_plot", 32'(bus.vga_plot), 32'(0));
    check("async_busy", 32'(bus.busy), 32'(0));
    bus.req = 4'b1111;
    tick();
    resetn = 1'b1;
    tick();
    check("post_reset_winner", 32'(bus.grant), 32'(1));

    // Owner drops request; pending engine 2 follows after the gap
    apply_reset();
    bus.req = 4'b0010;
    wait_grant(idx);
    check("owner1", 32'(idx), 32'(1));
    tick();
    bus.req[2] = 1'b1;
    tick();
    bus.req[1] = 1'b0;
    tick();
    check("drop_release", 32'(bus.grant), 32'(0));
    tick();
    check("drop_gap", 32'(bus.grant), 32'(0));
    tick();
    check("drop_next", 32'(bus.grant), 32'(4));

    // Owner never finishes
    apply_reset();
    bus.req = 4'b0001;
    wait_grant(idx);
    if (WD) begin
      n = 1;
      while (n < 100) begin
        tick();
        if (bus.grant == '0) break;
        n++;
      end
      check("wd_hold_cycles", 32'(n), 32'(MAX_HOLD));
      check("wd_timeout", 32'(bus.timeout), 32'(1));
      bus.req = 4'b0010;
      wait_grant(idx);
      check("wd_next", 32'(idx), 32'(1));
    end else begin
      to_seen = 1'b0;
      repeat (1000) begin
        tick();
        to_seen = to_seen | bus.timeout;
      end
      check("hold_grant", 32'(bus.grant), 32'(1));
      check("hold_timeout", 32'(to_seen), 32'(0));
    end

    // Randomized traffic against the model
    apply_reset();
    repeat (3000) begin
      for (int e = 0; e < NUM_REQ; e++) begin
        bus.done[e] = 1'b0;
        set_pix(e, int'($urandom_range(0, 1)), int'($urandom_range(0, 319)),
                int'($urandom_range(0, 239)), int'($urandom_range(0, 7)));
        if (e == m_owner) begin
          if ($urandom_range(0, 5) == 0) bus.done[e] = 1'b1;
          else if ($urandom_range(0, 39) == 0) bus.req[e] = 1'b0;
        end else begin
          if ($urandom_range(0, 15) == 0) bus.done[e] = 1'b1;
          if (!bus.req[e]) begin
            if ($urandom_range(0, 3) == 0) bus.req[e] = 1'b1;
          end else if ($urandom_range(0, 49) == 0) begin
            bus.req[e] = 1'b0;
          end
        end
      end
      if (exp_to) bus.req[m_last] = 1'b0;
      tick();
    end

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
